pipeline_sequencer: RTL and testbench
=====================================

PIPELINE_SEQUENCER -- requirements
Module: pipeline_sequencer

Interface
REQ-001 SHALL have one clock and an asynchronous active-low reset: CLK in 1 (all state updates on rising edge); RSTn in 1 (asynchronous, active-low).
REQ-002 SHALL have these ID-stage inputs: id_opcode in 7 (opcode of instruction in IF/ID); id_rs1 in 5; id_rs2 in 5 (source register fields).
REQ-003 SHALL have these EX-stage inputs: ex_memread in 1; ex_rd in 5 (destination in ID/EX); ex_redirect in 1 (taken branch or jump resolved in EX).
REQ-004 SHALL have these MEM-stage and system inputs: mem_req in 1 (MEM stage holds MemRead or MemWrite); dmem_ack in 1 (data memory done this cycle); halt_req in 1 (ID holds a halt instruction).
REQ-005 SHALL have these pipeline-control outputs, all 1 bit: pc_write, ifid_write, ifid_flush, idex_write, idex_flush, exmem_write, memwb_flush.
REQ-006 SHALL have these status outputs: state out 3; halted out 1; mem_timeout out 1 (sticky); stall_cycles out 16; flush_count out 16.

Function
REQ-007 SHALL implement FSM RUN=0, LDSTALL=1, MEMWAIT=2, DRAIN=3, HALT=4; encodings 5-7 SHALL go to RUN next cycle, with outputs as in RUN.
REQ-008 Control outputs SHALL be combinational in state and inputs; defaults are all *_write=1 and all *_flush=0.
REQ-009 rs1 use SHALL be true for every id_opcode except LUI 0110111, AUIPC 0010111 and JAL 1101111.
REQ-010 rs2 use SHALL be true only for R-type 0110011, store 0100011 and branch 1100011.
REQ-011 A load-use hazard SHALL exist when ex_memread=1, ex_rd!=0, and either ex_rd==id_rs1 with rs1 used, or ex_rd==id_rs2 with rs2 used.
REQ-012 RUN priority SHALL be, highest first: memory wait, redirect, halt, load-use.
REQ-013 Memory wait in RUN: when mem_req=1 and dmem_ack=0, all *_write SHALL be 0, memwb_flush SHALL be 1, and next state SHALL be MEMWAIT.
REQ-014 Redirect in RUN: when ex_redirect=1, ifid_flush SHALL be 1, idex_flush SHALL be 1, and state SHALL stay RUN; this overrides halt_req and load-use.
REQ-015 Halt in RUN: when halt_req=1, pc_write=0, ifid_write=0 and idex_flush=1 SHALL apply, the drain counter SHALL load 3, and next state SHALL be DRAIN.
REQ-016 Load-use in RUN: pc_write=0, ifid_write=0 and idex_flush=1 SHALL apply for exactly one cycle, and next state SHALL be LDSTALL.
REQ-017 LDSTALL SHALL use default outputs, SHALL not evaluate hazards, and SHALL go to RUN next, unless mem_req=1 and dmem_ack=0, which SHALL be handled as in REQ-013.
REQ-018 MEMWAIT SHALL drive the REQ-013 outputs and SHALL increment the 8-bit wait counter each cycle.
REQ-019 MEMWAIT SHALL go to RUN when dmem_ack=1, with default outputs that cycle and the wait counter cleared.
REQ-020 If the MEMWAIT wait counter reaches 255 without dmem_ack, mem_timeout SHALL set and next state SHALL be HALT.
REQ-021 DRAIN SHALL hold pc_write=0, ifid_write=0, idex_flush=1, let EX/MEM/WB advance, and decrement the drain counter each cycle.
REQ-022 DRAIN SHALL enter HALT when the drain counter reaches 0, so HALT is entered 4 edges after the halt_req cycle.
REQ-023 Memory wait during DRAIN SHALL freeze all stages as in REQ-013 and SHALL pause the drain counter.
REQ-024 HALT SHALL drive all *_write=0, memwb_flush=1 and halted=1, and SHALL leave only via reset.
REQ-025 stall_cycles SHALL increment, saturating at 0xFFFF, every cycle with pc_write=0 and state!=HALT.
REQ-026 flush_count SHALL increment, saturating at 0xFFFF, every cycle with ifid_flush=1.
REQ-027 An ex_redirect or halt_req that arrives while the pipeline is frozen SHALL be acted on only in the first unfrozen cycle; inputs are held by the frozen registers.

Reset
REQ-028 RSTn=0 SHALL asynchronously force: state=RUN, halted=0, mem_timeout=0, stall_cycles=0, flush_count=0, wait counter=0, drain counter=0.
REQ-029 While RSTn=0, outputs SHALL be RUN defaults, with combinational terms evaluated but no counters changing.
REQ-030 Deassertion of RSTn mid-MEMWAIT, mid-DRAIN or in HALT SHALL resume in RUN on the next edge.

Verification
REQ-031 Load-use: ex_memread=1, ex_rd=5, id_opcode=0110011, id_rs2=5 -> one cycle of pc_write=0 and idex_flush=1, then LDSTALL, then RUN; stall_cycles=1.
REQ-032 No-hazard cases: ex_rd=0, or id_opcode=LUI with id_rs1=ex_rd -> no stall and stall_cycles stays 0.
REQ-033 Redirect with hazard: ex_redirect=1 together with a load-use hazard -> ifid_flush=1 and idex_flush=1, pc_write=1, state stays RUN; flush_count=1.
REQ-034 Memory wait: mem_req=1, dmem_ack=0 for 3 cycles, then 1 -> 3 frozen cycles, resume; stall_cycles=3.
REQ-035 Memory timeout: mem_req=1, dmem_ack=0 for 300 cycles -> mem_timeout=1, halted=1, state=4; a later dmem_ack has no effect.
REQ-036 Halt and reset: halt_req=1 for 1 cycle -> state=4 and halted=1 after 4 edges; RSTn pulsed low mid-DRAIN -> state=0 and all counters 0 immediately.

Source files
------------

// File: rtl/pipeline_sequencer.sv
// Hazard/stall/flush sequencer for a 5-stage in-order pipeline.
// Latency: control outputs are combinational from state and inputs; status counters update one edge later.
// Backpressure: an unacknowledged data-memory access freezes every stage until dmem_ack or timeout.
module pipeline_sequencer (
    input  logic        CLK,
    input  logic        RSTn,
    input  logic [6:0]  id_opcode,
    input  logic [4:0]  id_rs1,
    input  logic [4:0]  id_rs2,
    input  logic        ex_memread,
    input  logic [4:0]  ex_rd,
    input  logic        ex_redirect,
    input  logic        mem_req,
    input  logic        dmem_ack,
    input  logic        halt_req,
    output logic        pc_write,
    output logic        ifid_write,
    output logic        ifid_flush,
    output logic        idex_write,
    output logic        idex_flush,
    output logic        exmem_write,
    output logic        memwb_flush,
    output logic [2:0]  state,
    output logic        halted,
    output logic        mem_timeout,
    output logic [15:0] stall_cycles,
    output logic [15:0] flush_count
);

    typedef enum logic [2:0] {
        RUN     = 3'd0,
        LDSTALL = 3'd1,
        MEMWAIT = 3'd2,
        DRAIN   = 3'd3,
        HALT    = 3'd4
    } state_t;

    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    state_t      state_q, state_nxt;
    logic [7:0]  wait_q, wait_nxt;
    logic [1:0]  drain_q, drain_nxt;
    logic        timeout_set;
    logic        freeze, hold_front, flush_if, flush_id;
    logic        rs1_used, rs2_used, load_use, mem_stall;

    assign rs1_used  = !(id_opcode == OP_LUI || id_opcode == OP_AUIPC || id_opcode == OP_JAL);
    assign rs2_used  = (id_opcode == OP_RTYPE) || (id_opcode == OP_STORE) || (id_opcode == OP_BRANCH);
    assign load_use  = ex_memread && (ex_rd != 5'd0) &&
                       (((ex_rd == id_rs1) && rs1_used) || ((ex_rd == id_rs2) && rs2_used));
    assign mem_stall = mem_req && !dmem_ack;

    always_comb begin
        state_nxt   = state_q;
        wait_nxt    = 8'd0;
        drain_nxt   = drain_q;
        timeout_set = 1'b0;
        freeze      = 1'b0;
        hold_front  = 1'b0;
        flush_if    = 1'b0;
        flush_id    = 1'b0;
        case (state_q)
            RUN: begin
                if (mem_stall) begin
                    freeze    = 1'b1;
                    state_nxt = MEMWAIT;
                end else if (ex_redirect) begin
                    flush_if = 1'b1;
                    flush_id = 1'b1;
                end else if (halt_req) begin
                    hold_front = 1'b1;
                    flush_id   = 1'b1;
                    drain_nxt  = 2'd3;
                    state_nxt  = DRAIN;
                end else if (load_use) begin
                    hold_front = 1'b1;
                    flush_id   = 1'b1;
                    state_nxt  = LDSTALL;
                end
            end
            LDSTALL: begin
                if (mem_stall) begin
                    freeze    = 1'b1;
                    state_nxt = MEMWAIT;
                end else begin
                    state_nxt = RUN;
                end
            end
            MEMWAIT: begin
                if (dmem_ack) begin
                    state_nxt = RUN;
                end else begin
                    freeze   = 1'b1;
                    wait_nxt = wait_q + 8'd1;
                    // This cycle brings the count to 255 with no acknowledge.
                    if (wait_q == 8'd254) begin
                        timeout_set = 1'b1;
                        state_nxt   = HALT;
                    end
                end
            end
            DRAIN: begin
                if (mem_stall) begin
                    freeze = 1'b1;
                end else begin
                    hold_front = 1'b1;
                    flush_id   = 1'b1;
                    drain_nxt  = drain_q - 2'd1;
                    if (drain_q <= 2'd1) state_nxt = HALT;
                end
            end
            HALT: begin
                freeze = 1'b1;
            end
            default: begin
                state_nxt = RUN;
            end
        endcase
    end

    assign pc_write    = !(freeze || hold_front);
    assign ifid_write  = !(freeze || hold_front);
    assign idex_write  = !freeze;
    assign exmem_write = !freeze;
    assign ifid_flush  = flush_if;
    assign idex_flush  = flush_id && !freeze;
    assign memwb_flush = freeze;

    assign state  = state_q;
    assign halted = (state_q == HALT);

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            state_q      <= RUN;
            wait_q       <= 8'd0;
            drain_q      <= 2'd0;
            mem_timeout  <= 1'b0;
            stall_cycles <= 16'd0;
            flush_count  <= 16'd0;
        end else begin
            state_q <= state_nxt;
            wait_q  <= wait_nxt;
            drain_q <= drain_nxt;
            if (timeout_set) mem_timeout <= 1'b1;
            if (!pc_write && (state_q != HALT) && (stall_cycles != 16'hFFFF))
                stall_cycles <= stall_cycles + 16'd1;
            if (ifid_flush && (flush_count != 16'hFFFF))
                flush_count <= flush_count + 16'd1;
        end
    end

endmodule

// File: tb/tb_pipeline_sequencer.sv
// Directed bench: stimulus pushes hand-computed expectations per cycle,
// a negedge monitor pops and compares them against the DUT.
module tb_pipeline_sequencer;

    logic        CLK = 1'b0;
    logic        RSTn;
    logic [6:0]  id_opcode;
    logic [4:0]  id_rs1, id_rs2, ex_rd;
    logic        ex_memread, ex_redirect, mem_req, dmem_ack, halt_req;
    logic        pc_write, ifid_write, ifid_flush, idex_write, idex_flush, exmem_write, memwb_flush;
    logic [2:0]  state;
    logic        halted, mem_timeout;
    logic [15:0] stall_cycles, flush_count;

    // ctrl order: {pc_write, ifid_write, idex_write, exmem_write, ifid_flush, idex_flush, memwb_flush}
    localparam logic [6:0] DEF = 7'b1111_000;
    localparam logic [6:0] FRZ = 7'b0000_001;
    localparam logic [6:0] LDU = 7'b0011_010;
    localparam logic [6:0] RDR = 7'b1111_110;

    typedef struct {
        string       nm;
        int          cyc;
        logic [6:0]  ctrl;
        logic [2:0]  st;
        logic        hl;
        logic        to;
        logic [15:0] stl;
        logic [15:0] fl;
    } exp_t;

    exp_t exp_q[$];
    int   cyc    = 0;
    int   npass  = 0;
    int   ntotal = 0;

    pipeline_sequencer dut (
        .CLK(CLK), .RSTn(RSTn),
        .id_opcode(id_opcode), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .ex_memread(ex_memread), .ex_rd(ex_rd), .ex_redirect(ex_redirect),
        .mem_req(mem_req), .dmem_ack(dmem_ack), .halt_req(halt_req),
        .pc_write(pc_write), .ifid_write(ifid_write), .ifid_flush(ifid_flush),
        .idex_write(idex_write), .idex_flush(idex_flush), .exmem_write(exmem_write),
        .memwb_flush(memwb_flush), .state(state), .halted(halted),
        .mem_timeout(mem_timeout), .stall_cycles(stall_cycles), .flush_count(flush_count)
    );

    always #5 CLK = ~CLK;
    always @(posedge CLK) cyc <= cyc + 1;

    always @(negedge CLK) begin
        exp_t e;
        logic [6:0] act;
        act = {pc_write, ifid_write, idex_write, exmem_write, ifid_flush, idex_flush, memwb_flush};
        while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
            e = exp_q.pop_front();
            ntotal++;
            $display("FAIL %s: expectation for cycle %0d never sampled (now %0d)", e.nm, e.cyc, cyc);
        end
        if (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
            e = exp_q.pop_front();
            ntotal++;
            if (act === e.ctrl && state === e.st && halted === e.hl && mem_timeout === e.to &&
                stall_cycles === e.stl && flush_count === e.fl) begin
                npass++;
            end else begin
                $display("FAIL %s cyc=%0d got ctrl=%b st=%0d hl=%b to=%b stall=%0d flush=%0d want ctrl=%b st=%0d hl=%b to=%b stall=%0d flush=%0d",
                         e.nm, cyc, act, state, halted, mem_timeout, stall_cycles, flush_count,
                         e.ctrl, e.st, e.hl, e.to, e.stl, e.fl);
            end
        end
    end

    task automatic idle();
        id_opcode   = 7'b0010011;
        id_rs1      = 5'd0;
        id_rs2      = 5'd0;
        ex_memread  = 1'b0;
        ex_rd       = 5'd0;
        ex_redirect = 1'b0;
        mem_req     = 1'b0;
        dmem_ack    = 1'b0;
        halt_req    = 1'b0;
    endtask

    task automatic hazard(input logic [6:0] op, input logic [4:0] rs1, input logic [4:0] rs2,
                          input logic mr, input logic [4:0] rd);
        idle();
        id_opcode  = op;
        id_rs1     = rs1;
        id_rs2     = rs2;
        ex_memread = mr;
        ex_rd      = rd;
    endtask

    // Inputs already applied for this cycle; expectation covers this cycle, then advance.
    task automatic chk(input string nm, input logic [6:0] c, input logic [2:0] st,
                       input logic hl, input logic to, input int stl, input int fl);
        exp_t e;
        e.nm   = nm;
        e.cyc  = cyc;
        e.ctrl = c;
        e.st   = st;
        e.hl   = hl;
        e.to   = to;
        e.stl  = 16'(stl);
        e.fl   = 16'(fl);
        exp_q.push_back(e);
        @(posedge CLK);
        #1;
    endtask

    initial begin
        #20000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        idle();
        RSTn = 1'b0;
        @(posedge CLK);
        #1;
        chk("reset", DEF, 3'd0, 0, 0, 0, 0);
        RSTn = 1'b1;
        chk("idle0", DEF, 3'd0, 0, 0, 0, 0);

        // Load-use on rs2 of an R-type; LDSTALL ignores the still-present hazard
        hazard(7'b0110011, 5'd7, 5'd5, 1'b1, 5'd5);
        chk("lu_rs2", LDU, 3'd0, 0, 0, 0, 0);
        chk("ldstall", DEF, 3'd1, 0, 0, 1, 0);
        idle();
        chk("lu_resume", DEF, 3'd0, 0, 0, 1, 0);

        hazard(7'b0110011, 5'd0, 5'd0, 1'b1, 5'd0);
        chk("nh_rd0", DEF, 3'd0, 0, 0, 1, 0);
        hazard(7'b0110111, 5'd5, 5'd3, 1'b1, 5'd5);
        chk("nh_lui", DEF, 3'd0, 0, 0, 1, 0);
        hazard(7'b1101111, 5'd5, 5'd3, 1'b1, 5'd5);
        chk("nh_jal", DEF, 3'd0, 0, 0, 1, 0);
        hazard(7'b0010111, 5'd5, 5'd3, 1'b1, 5'd5);
        chk("nh_auipc", DEF, 3'd0, 0, 0, 1, 0);
        hazard(7'b0000011, 5'd1, 5'd5, 1'b1, 5'd5);
        chk("nh_rs2unused", DEF, 3'd0, 0, 0, 1, 0);
        hazard(7'b0110011, 5'd5, 5'd5, 1'b0, 5'd5);
        chk("nh_noload", DEF, 3'd0, 0, 0, 1, 0);

        hazard(7'b1100011, 5'd5, 5'd2, 1'b1, 5'd5);
        chk("lu_br", LDU, 3'd0, 0, 0, 1, 0);
        idle();
        chk("ldstall2", DEF, 3'd1, 0, 0, 2, 0);
        chk("run2", DEF, 3'd0, 0, 0, 2, 0);

        // Redirect outranks load-use and halt
        hazard(7'b0100011, 5'd1, 5'd9, 1'b1, 5'd9);
        ex_redirect = 1'b1;
        chk("rdr_lu", RDR, 3'd0, 0, 0, 2, 0);
        idle();
        chk("rdr_after", DEF, 3'd0, 0, 0, 2, 1);
        ex_redirect = 1'b1;
        halt_req    = 1'b1;
        chk("rdr_halt", RDR, 3'd0, 0, 0, 2, 1);
        idle();
        chk("rdr_halt_after", DEF, 3'd0, 0, 0, 2, 2);

        // Memory wait outranks redirect; redirect acted on only after unfreeze
        ex_redirect = 1'b1;
        mem_req     = 1'b1;
        chk("mw_run", FRZ, 3'd0, 0, 0, 2, 2);
        chk("mw1", FRZ, 3'd2, 0, 0, 3, 2);
        chk("mw2", FRZ, 3'd2, 0, 0, 4, 2);
        dmem_ack = 1'b1;
        chk("mw_ack", DEF, 3'd2, 0, 0, 5, 2);
        mem_req  = 1'b0;
        dmem_ack = 1'b0;
        chk("mw_rdr", RDR, 3'd0, 0, 0, 5, 2);
        idle();
        chk("mw_done", DEF, 3'd0, 0, 0, 5, 3);

        hazard(7'b0110011, 5'd7, 5'd5, 1'b1, 5'd5);
        chk("lu3", LDU, 3'd0, 0, 0, 5, 3);
        idle();
        mem_req = 1'b1;
        chk("ld_mw", FRZ, 3'd1, 0, 0, 6, 3);
        dmem_ack = 1'b1;
        chk("ld_mw_ack", DEF, 3'd2, 0, 0, 7, 3);
        idle();
        chk("ld_mw_run", DEF, 3'd0, 0, 0, 7, 3);

        // Halt with a memory wait pausing the drain
        halt_req = 1'b1;
        chk("halt_a", LDU, 3'd0, 0, 0, 7, 3);
        idle();
        chk("drain_a1", LDU, 3'd3, 0, 0, 8, 3);
        mem_req = 1'b1;
        chk("drain_a_mw", FRZ, 3'd3, 0, 0, 9, 3);
        idle();
        chk("drain_a2", LDU, 3'd3, 0, 0, 10, 3);
        chk("drain_a3", LDU, 3'd3, 0, 0, 11, 3);
        chk("halted_a", FRZ, 3'd4, 1, 0, 12, 3);
        dmem_ack    = 1'b1;
        ex_redirect = 1'b1;
        halt_req    = 1'b1;
        chk("halt_hold", FRZ, 3'd4, 1, 0, 12, 3);
        idle();
        RSTn = 1'b0;
        chk("rst_halt", DEF, 3'd0, 0, 0, 0, 0);
        RSTn = 1'b1;
        chk("post_rst", DEF, 3'd0, 0, 0, 0, 0);

        halt_req = 1'b1;
        chk("halt_b", LDU, 3'd0, 0, 0, 0, 0);
        idle();
        chk("drain_b1", LDU, 3'd3, 0, 0, 1, 0);
        chk("drain_b2", LDU, 3'd3, 0, 0, 2, 0);
        chk("drain_b3", LDU, 3'd3, 0, 0, 3, 0);
        chk("halted_b", FRZ, 3'd4, 1, 0, 4, 0);
        RSTn = 1'b0;
        chk("rst2", DEF, 3'd0, 0, 0, 0, 0);
        RSTn     = 1'b1;
        halt_req = 1'b1;
        chk("halt_c", LDU, 3'd0, 0, 0, 0, 0);
        idle();
        chk("drain_c1", LDU, 3'd3, 0, 0, 1, 0);
        RSTn = 1'b0;
        chk("rst_drain", DEF, 3'd0, 0, 0, 0, 0);
        RSTn = 1'b1;
        chk("rst_drain_rel", DEF, 3'd0, 0, 0, 0, 0);
        chk("run_c", DEF, 3'd0, 0, 0, 0, 0);

        // Memory timeout: 1 RUN cycle + 255 MEMWAIT cycles, then HALT
        mem_req = 1'b1;
        for (int i = 0; i < 300; i++) begin
            if (i == 0)
                chk("to_run", FRZ, 3'd0, 0, 0, 0, 0);
            else if (i <= 255)
                chk("to_wait", FRZ, 3'd2, 0, 0, i, 0);
            else
                chk("to_halt", FRZ, 3'd4, 1, 1, 256, 0);
        end
        dmem_ack = 1'b1;
        chk("to_ack", FRZ, 3'd4, 1, 1, 256, 0);
        chk("to_ack2", FRZ, 3'd4, 1, 1, 256, 0);
        idle();
        RSTn = 1'b0;
        chk("rst_to", DEF, 3'd0, 0, 0, 0, 0);
        RSTn = 1'b1;

        @(negedge CLK);
        #1;
        ntotal++;
        if (exp_q.size() == 0)
            npass++;
        else
            $display("FAIL drain_queue: %0d expectations left, want 0", exp_q.size());
        $display("%0d/%0d checks passed", npass, ntotal);
        $finish;
    end

endmodule
